// File: rtl/reg_file_pkg.sv
// Shared register-file constants.
// Used by the register file and its writeback arbiter.
package reg_file_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 64;
  localparam int REG_NUM = 32;
  localparam int WB_NREQ_DEFAULT = 3;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant generator.
// Owns the rotating priority pointer.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk_i,
  input  logic            nrst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            hold_i,
  input  logic            xfer_i,
  output logic [NREQ-1:0] gnt_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   idx;
  logic            found;
  logic [NREQ-1:0] gnt;

  // Search from ptr upward, wrapping modulo NREQ
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_i[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    if (hold_i || !nrst_i) gnt = '0;
  end

  assign gnt_o = gnt;

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer_i && gnt[i]) ptr_d = PW'((i + 1) % NREQ);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the register file write port.
// Round-robin grant, registered write outputs.
module reg_wb_arbiter
  import reg_file_pkg::*;
#(
  parameter int NREQ = WB_NREQ_DEFAULT,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             hold_i,
  input  logic [NREQ-1:0]  req_valid_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]  req_ready_o,
  output logic             RegWrite_o,
  output logic [AW-1:0]    RDaddr_o,
  output logic [DW-1:0]    RDdata_o,
  output logic             busy_o
);
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .req_i  (req_valid_i),
    .hold_i (hold_i),
    .xfer_i (xfer),
    .gnt_o  (gnt)
  );

  assign req_ready_o = gnt;
  assign xfer        = |(gnt & req_valid_i);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr_i[i*AW +: AW];
        sel_data = sel_data | req_data_i[i*DW +: DW];
      end
    end
  end

  // Register 0 handshakes normally but never raises the write enable
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (xfer) begin
      we_d   = (sel_addr != AW'(ZERO_REG));
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign RegWrite_o = we_q;
  assign RDaddr_o   = addr_q;
  assign RDdata_o   = data_q;
  assign busy_o     = we_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: queued requesters,
// behavioural model compare, directed literal checks.
module tb_reg_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic hold = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] ready;
  logic rw;
  logic [AW-1:0] rda;
  logic [DW-1:0] rdd;
  logic busy;

  int n_run = 0;
  int n_fail = 0;

  reg_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .hold_i      (hold),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (ready),
    .RegWrite_o  (rw),
    .RDaddr_o    (rda),
    .RDdata_o    (rdd),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester queues
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } item_t;
  item_t q0[$];
  item_t q1[$];
  item_t q2[$];

  task automatic push(int r, logic [AW-1:0] a, logic [DW-1:0] d);
    item_t it;
    it.a = a;
    it.d = d;
    case (r)
      0: q0.push_back(it);
      1: q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endtask

  task automatic present();
    req_valid = '0;
    if (q0.size() > 0) begin
      req_valid[0] = 1'b1;
      req_addr[0*AW +: AW] = q0[0].a;
      req_data[0*DW +: DW] = q0[0].d;
    end
    if (q1.size() > 0) begin
      req_valid[1] = 1'b1;
      req_addr[1*AW +: AW] = q1[0].a;
      req_data[1*DW +: DW] = q1[0].d;
    end
    if (q2.size() > 0) begin
      req_valid[2] = 1'b1;
      req_addr[2*AW +: AW] = q2[0].a;
      req_data[2*DW +: DW] = q2[0].d;
    end
  endtask

  // One clock: sample handshake mid-cycle, pop after edge
  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = req_valid & ready;
    @(posedge clk);
    #1;
    if (fire[0]) void'(q0.pop_front());
    if (fire[1]) void'(q1.pop_front());
    if (fire[2]) void'(q2.pop_front());
    present();
  endtask

  // Behavioural model
  int m_ptr;
  logic m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int mg;
  int cg;

  function automatic int mgrant();
    if (!nrst || hold) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_ptr  <= 0;
      m_we   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
    end else begin
      mg = mgrant();
      if (mg >= 0) begin
        m_we   <= (req_addr[mg*AW +: AW] != 0);
        m_addr <= req_addr[mg*AW +: AW];
        m_data <= req_data[mg*DW +: DW];
        m_ptr  <= (mg + 1) % N;
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  // Register file stand-in and per-cycle compare
  logic [DW-1:0] rf[32];
  logic [N-1:0] pv = '0;
  logic [N-1:0] pf = '0;
  logic [N*AW-1:0] pa = '0;
  logic [N*DW-1:0] pd = '0;
  logic [N-1:0] eg;

  always @(negedge clk) begin
    cg = mgrant();
    eg = '0;
    if (cg >= 0) eg[cg] = 1'b1;
    chk("ready", 128'(ready), 128'(eg));
    chk("regwrite", 128'(rw), 128'(m_we));
    chk("busy", 128'(busy), 128'(m_we));
    chk("rdaddr", 128'(rda), 128'(m_addr));
    chk("rddata", 128'(rdd), 128'(m_data));
    for (int i = 0; i < N; i++) begin
      if (pv[i] && !pf[i])
        chk("req_stable",
            {req_valid[i], req_addr[i*AW +: AW], req_data[i*DW +: DW]},
            {1'b1, pa[i*AW +: AW], pd[i*DW +: DW]});
    end
    pv = req_valid;
    pf = req_valid & ready;
    pa = req_addr;
    pd = req_data;
    if (!nrst) begin
      foreach (rf[j]) rf[j] = '0;
    end else if (rw && rda != 0) begin
      rf[rda] = rdd;
    end
  end

  int exp_a[6] = '{1, 2, 3, 1, 2, 3};
  logic [DW-1:0] va = 64'hAAAA_0000_0000_000A;
  logic [DW-1:0] vb = 64'hBBBB_0000_0000_000B;

  initial begin
    foreach (rf[j]) rf[j] = '0;
    step();
    step();
    chk("rst_regwrite", 128'(rw), 128'(0));
    chk("rst_rdaddr", 128'(rda), 128'(0));
    chk("rst_ready", 128'(ready), 128'(0));
    nrst = 1'b1;

    // Single requester
    push(1, 5'd5, 64'hDEAD_BEEF_0000_0001);
    present();
    #1 chk("single_ready", 128'(ready), 128'(3'b010));
    step();
    chk("single_we", 128'(rw), 128'(1));
    chk("single_addr", 128'(rda), 128'(5));
    chk("single_data", 128'(rdd), 128'(64'hDEAD_BEEF_0000_0001));
    step();
    chk("single_we_off", 128'(rw), 128'(0));
    chk("single_addr_hold", 128'(rda), 128'(5));

    // Zero register, pointer at 2
    push(0, 5'd0, 64'h1234);
    push(1, 5'd7, 64'h77);
    present();
    #1 chk("zero_ready", 128'(ready), 128'(3'b001));
    step();
    chk("zero_we", 128'(rw), 128'(0));
    chk("zero_data", 128'(rdd), 128'(64'h1234));
    chk("zero_next_ready", 128'(ready), 128'(3'b010));
    step();
    chk("after_zero_we", 128'(rw), 128'(1));
    chk("after_zero_addr", 128'(rda), 128'(7));

    // Hold: pending write drains, no grants
    hold = 1'b1;
    push(2, 5'd12, 64'hC0FF_EE00);
    present();
    #1 chk("hold_ready0", 128'(ready), 128'(0));
    chk("hold_drain_we", 128'(rw), 128'(1));
    for (int c = 0; c < 4; c++) begin
      step();
      chk("hold_ready", 128'(ready), 128'(0));
      chk("hold_we", 128'(rw), 128'(0));
    end
    hold = 1'b0;
    #1 chk("unhold_ready", 128'(ready), 128'(3'b100));
    step();
    chk("unhold_we", 128'(rw), 128'(1));
    chk("unhold_addr", 128'(rda), 128'(12));

    // Round-robin, pointer at 0
    for (int r = 0; r < N; r++) begin
      push(r, 5'(r + 1), 64'(100 + r));
      push(r, 5'(r + 1), 64'(200 + r));
    end
    present();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_we", 128'(rw), 128'(1));
      chk("rr_addr", 128'(rda), 128'(exp_a[k]));
    end
    step();
    chk("rr_idle", 128'(rw), 128'(0));

    // Same-address conflict, pointer at 0
    push(0, 5'd9, va);
    push(1, 5'd9, vb);
    present();
    step();
    chk("conf_first", 128'(rdd), 128'(va));
    step();
    chk("conf_second", 128'(rdd), 128'(vb));
    chk("conf_addr", 128'(rda), 128'(9));
    step();
    chk("conf_file", 128'(rf[9]), 128'(vb));

    // Reset mid-operation, pointer at 2
    push(1, 5'd4, 64'h44);
    present();
    step();
    chk("pre_rst_we", 128'(rw), 128'(1));
    push(0, 5'd10, 64'h1010);
    push(2, 5'd13, 64'h1313);
    present();
    #1 nrst = 1'b0;
    #1;
    chk("arst_we", 128'(rw), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_addr", 128'(rda), 128'(0));
    chk("arst_data", 128'(rdd), 128'(0));
    chk("arst_ready", 128'(ready), 128'(0));
    step();
    chk("rst_hold_ready", 128'(ready), 128'(0));
    step();
    nrst = 1'b1;
    #1 chk("post_rst_ready", 128'(ready), 128'(3'b001));
    step();
    chk("post_rst_addr0", 128'(rda), 128'(10));
    step();
    chk("post_rst_addr1", 128'(rda), 128'(13));
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter for the 32 x 64-bit register file. It shares the file's single write port (RegWrite/RDaddr/RDdata) between NREQ writeback requesters, such as the ALU, load unit and mul/div unit. Arbitration is round-robin with a valid/ready handshake, and the output is registered. The block sits between the writeback sources and the register file write inputs.

## Interface
Parameters:
- NREQ, 3: number of writeback requesters (2..8)
- AW, 5: register address width
- DW, 64: register data width

Ports:
- clk_i  in  1  single clock, all state updates on rising edge
- nrst_i  in  1  asynchronous, active-low reset
- hold_i  in  1  when 1, no grants issued (port reserved for external use)
- req_valid_i  in  NREQ  per-requester write request
- req_addr_i  in  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW]
- req_data_i  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- req_ready_o  out  NREQ  one-hot grant/accept, combinational
- RegWrite_o  out  1  register-file write enable, registered
- RDaddr_o  out  AW  register-file write address, registered
- RDdata_o  out  DW  register-file write data, registered
- busy_o  out  1  RegWrite_o pending this cycle (equals RegWrite_o)

## Operation
- Transfer for requester i occurs when req_valid_i[i] and req_ready_o[i] are both 1 at a rising edge.
- Requester rule: once valid is raised, valid, addr and data stay stable until the transfer. The bench flags any violation.
- req_ready_o is one-hot or zero.
  - It is zero when hold_i is 1, when nrst_i is 0, or when no valid request is present.
  - req_ready_o never depends on req_ready_o feedback. It depends only on valid, hold_i and the pointer.
- Round-robin: rr_ptr is in 0..NREQ-1.
  - Grant goes to the first valid requester found searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - After any transfer to i, rr_ptr becomes (i+1) mod NREQ.
  - With no transfer, rr_ptr holds.
- Fairness: a continuously valid requester is granted within NREQ non-hold cycles.
- Output register on the edge of a transfer:
  - RDaddr_o and RDdata_o load the granted address and data.
  - RegWrite_o loads 1, unless the address is 0. Register 0 is read-only by convention.
  - A write to address 0 completes its handshake and advances rr_ptr, but RegWrite_o stays 0.
- On an edge with no transfer: RegWrite_o goes to 0; RDaddr_o and RDdata_o hold their last values.
- Same-address requests in the same cycle from two requesters are serialized in round-robin order. The later grant overwrites the earlier one in the register file.

## Timing
- Reset values, applied asynchronously: RegWrite_o=0, busy_o=0, RDaddr_o=0, RDdata_o=0, rr_ptr=0.
- While nrst_i=0, req_ready_o=0.
- Reset mid-operation:
  - A write in the output stage that has not yet been written to the file is lost. Both blocks share nrst_i, so the file is cleared too.
  - Requests not yet handshaked are re-arbitrated from rr_ptr=0 after release.
- Latency: transfer at edge N, then RegWrite_o=1 during cycle N+1, then the register file captures at edge N+1→N+2.
- Throughput: one transfer per cycle while any valid and hold_i=0.
- hold_i:
  - Asserting it at cycle C blocks the grant in cycle C.
  - A write already in the output stage still completes.
  - Deasserting it grants in the same cycle.

## Structure
- Shared package reg_file_pkg: REG_AW=5, REG_DW=64, REG_NUM=32, WB_NREQ_DEFAULT=3, ZERO_REG=5'd0. The register file and this block use the same constants.
- One sub-module, rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, hold, transfer-accepted; output: one-hot grant.
  - Owns rr_ptr; asynchronous active-low reset.
- The top level holds the packed-bus mux and the output register.

## Test plan
- Reset: assert nrst_i mid-cycle with RegWrite_o=1 → RegWrite_o=0, RDaddr_o=0, RDdata_o=0 immediately; req_ready_o=0 throughout. After release, the first grant goes to requester 0.
- Single requester: req1 valid, addr 5, data 64'hDEAD_BEEF_0000_0001 → ready[1]=1 in the same cycle; next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=64'hDEAD_BEEF_0000_0001; one cycle after that, RegWrite_o=0.
- Round-robin: all three valid continuously with addresses 1, 2, 3 → grant order 0,1,2,0,1,2; RDaddr_o sequence 1,2,3,1,2,3 on back-to-back cycles, with RegWrite_o held at 1.
- Zero register: req0 writes addr 0, data 64'h1234 → handshake completes and RegWrite_o stays 0. Then req1 (addr 7) is granted next, confirming the pointer advanced.
- hold_i: req2 valid with hold_i=1 for 4 cycles → ready=0 and RegWrite_o=0 throughout. When hold drops, the grant occurs the same cycle, with RegWrite_o=1 in the next cycle.
- Same-address conflict: req0 and req1 both target addr 9, data A and B, with rr_ptr=0 → writes A then B on consecutive cycles; the file reads B afterwards.
